// File: rtl/normaliza.sv
// Iterative post-add normalizer: walks the sum fraction until the leading 1 sits at the hidden bit.
// Optional NORMALIZA_LZC_EN: left shifts resolve in one cycle via a leading-zero count.
module normaliza #(
  parameter int EXP_W   = 8,
  parameter int FRAC_W  = 29,
  parameter int EXP_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [FRAC_W-1:0] fract_in,
  output logic              busy,
  output logic              done,
  output logic              normalized,
  output logic [EXP_W-1:0]  exp_out,
  output logic [FRAC_W-1:0] fract_out,
  output logic              overflow,
  output logic              underflow
);

  localparam int HID = FRAC_W - 3;
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_MAX - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_reg, state_next;
  logic [EXP_W-1:0]   exp_reg, exp_next;
  logic [FRAC_W-1:0]  fract_reg, fract_next;
  logic [EXP_W-1:0]   exp_out_next;
  logic [FRAC_W-1:0]  fract_out_next;
  logic               nrm_next, ovf_next, unf_next;

`ifdef NORMALIZA_LZC_EN
  localparam int SH_W = $clog2(HID + 1);
  logic [SH_W-1:0] lz_shamt;

  // Highest set bit below the hidden bit wins, giving the smallest shift.
  always_comb begin
    lz_shamt = '0;
    for (int i = 0; i < HID; i++) begin
      if (fract_reg[i]) lz_shamt = SH_W'(HID - i);
    end
  end
`endif

  assign busy = (state_reg == SHIFT);
  assign done = (state_reg == DONE);

  always_comb begin
    state_next     = state_reg;
    exp_next       = exp_reg;
    fract_next     = fract_reg;
    exp_out_next   = exp_out;
    fract_out_next = fract_out;
    nrm_next       = normalized;
    ovf_next       = overflow;
    unf_next       = underflow;
    case (state_reg)
      IDLE: begin
        if (start) begin
          exp_next   = exp_in;
          fract_next = fract_in;
          nrm_next   = 1'b0;
          ovf_next   = 1'b0;
          unf_next   = 1'b0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (fract_reg == '0) begin
          exp_out_next   = '0;
          fract_out_next = '0;
          nrm_next       = 1'b1;
          state_next     = DONE;
        end else if (fract_reg[FRAC_W-1] || fract_reg[FRAC_W-2]) begin
          if (exp_reg == EXP_TOP) begin
            exp_out_next   = EXP_W'(EXP_MAX);
            fract_out_next = '0;
            ovf_next       = 1'b1;
            nrm_next       = 1'b0;
            state_next     = DONE;
          end else begin
            // Bits shifted out are folded into the sticky bit.
            fract_next = {1'b0, fract_reg[FRAC_W-1:2], fract_reg[1] | fract_reg[0]};
            exp_next   = exp_reg + 1'b1;
          end
        end else if (fract_reg[HID]) begin
          exp_out_next   = exp_reg;
          fract_out_next = fract_reg;
          nrm_next       = 1'b1;
          state_next     = DONE;
        end else begin
`ifdef NORMALIZA_LZC_EN
          if (exp_reg <= EXP_W'(1)) begin
            exp_out_next   = '0;
            fract_out_next = fract_reg;
            unf_next       = 1'b1;
            nrm_next       = 1'b0;
            state_next     = DONE;
          end else if (EXP_W'(lz_shamt) < exp_reg) begin
            fract_next = fract_reg << lz_shamt;
            exp_next   = exp_reg - EXP_W'(lz_shamt);
          end else begin
            // Shift clamped so the exponent would land at 1; report as denormal.
            exp_out_next   = '0;
            fract_out_next = fract_reg << (exp_reg - 1'b1);
            unf_next       = 1'b1;
            nrm_next       = 1'b0;
            state_next     = DONE;
          end
`else
          if (exp_reg > EXP_W'(1)) begin
            fract_next = fract_reg << 1;
            exp_next   = exp_reg - 1'b1;
          end else begin
            exp_out_next   = '0;
            fract_out_next = fract_reg;
            unf_next       = 1'b1;
            nrm_next       = 1'b0;
            state_next     = DONE;
          end
`endif
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      exp_reg    <= '0;
      fract_reg  <= '0;
      exp_out    <= '0;
      fract_out  <= '0;
      normalized <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      exp_reg    <= exp_next;
      fract_reg  <= fract_next;
      exp_out    <= exp_out_next;
      fract_out  <= fract_out_next;
      normalized <= nrm_next;
      overflow   <= ovf_next;
      underflow  <= unf_next;
    end
  end

endmodule

// File: doc/normaliza.md
Name: normaliza

Overview:
- Iterative post-add normalization stage of the single-precision floating-point adder datapath.
- Takes the raw 29-bit sum fraction and its exponent from the add/subtract stage.
- Shifts the fraction one position per cycle until the leading 1 sits at bit 26, adjusting the exponent to match.
- Produces the `normalized` flag, exponent and fraction consumed directly by the rounding stage.

Parameters:
- EXP_W, 8, exponent width
- FRAC_W, 29, fraction width: [28:27] carry bits, [26] hidden bit, [25:3] mantissa, [2:0] guard/round/sticky
- EXP_MAX, 255, all-ones exponent (Inf/NaN code)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- start  input  1  load request; sampled only in IDLE
- exp_in  input  8  unnormalized exponent
- fract_in  input  29  unnormalized fraction
- busy  output  1  high from load until completion
- done  output  1  one-cycle pulse when outputs are updated
- normalized  output  1  1 = fract_out normal (bit 26 set) or exact zero; 0 = denormal or overflow, rounder passes through
- exp_out  output  8  result exponent
- fract_out  output  29  result fraction
- overflow  output  1  exponent saturated to 255
- underflow  output  1  result denormal (exp_out = 0)

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0. Asserting reset mid-operation aborts immediately; no done pulse.
- FSM IDLE -> SHIFT -> DONE -> IDLE.
- IDLE, start=1 at edge k: load internal exp_r/fract_r at edge k; busy=1 from k; state SHIFT.
- SHIFT: each edge evaluates exactly one of the following, in priority order:
  1. fract_r == 0: result exp 0, fract 0, normalized=1; finish.
  2. fract_r[28] or fract_r[27] set: right shift by 1; new[0] = old[1] | old[0] (sticky preserved); exp_r+1.
     - If exp_r == 254 before the shift: finish with overflow=1, exp_out=255, fract_out=0, normalized=0.
  3. fract_r[26] set: finish, normalized=1.
  4. Otherwise (leading 1 below bit 26):
     - exp_r > 1: left shift by 1, zero fill, exp_r-1.
     - exp_r <= 1: finish with exp_out=0, fract_out=fract_r, underflow=1, normalized=0.
- Finish edge: exp_out/fract_out/flags registered; done=1 for exactly that cycle; busy=0; state returns through DONE to IDLE.
- Outputs hold until the next finish or reset. Flags are cleared on each new load.
- start while busy=1 or in DONE: ignored, not queued.
- Latency (start edge k):
  - already normal: done at k+1
  - n right shifts: k+1+n (n ≤ 2)
  - n left shifts: k+1+n (n ≤ 26)
- Right shift from exp_r=0 is allowed: a carry out of a denormal gives exp 1.
- All exponent arithmetic is unsigned 8-bit; the rules above prevent wrap.

Optional Feature:
- NORMALIZA_LZC_EN.
- Defined: left shifts complete in a single SHIFT cycle. A leading-zero count over fract_r[25:0] gives shift amount s, clamped to exp_r-1.
  - Clamped case: underflow result as above, at the same cycle.
  - Right shifts stay serial.
  - Left-shift latency becomes k+2.
- Undefined: serial one-bit-per-cycle left shifts as in Behaviour.
- Output values are identical in both builds; only latency differs.

Test Plan:
- exp_in=0x80, fract_in=0x04000008, start -> done at k+1, normalized=1, exp_out=0x80, fract_out=0x04000008, flags 0.
- exp_in=0x7F, fract_in=0x10000003 -> two right shifts, done at k+3, exp_out=0x81, fract_out=0x04000001 (sticky kept), normalized=1.
- exp_in=0x10, fract_in=0x00200000 -> exp_out=0x0B, fract_out=0x04000000, normalized=1. Done at k+6 serial, k+2 with NORMALIZA_LZC_EN.
- exp_in=0x03, fract_in=0x00000100 -> exp_out=0x00, fract_out=0x00000400, underflow=1, normalized=0.
- exp_in=0xFE, fract_in=0x08000000 -> exp_out=0xFF, fract_out=0, overflow=1, normalized=0, done at k+1.
- fract_in=0 gives exp_out=0, fract_out=0, normalized=1. Second start while busy is ignored. rst_n low mid-shift -> all outputs 0 immediately, no done pulse, next start processes normally.
